ysyx_23060061_mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares the core's single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU). Replaces the direct wiring of inst / memDataR / memDataW / memAddrW once the core moves to a multi-cycle, handshake-based memory interface. Supports one outstanding transaction, round-robin grant, registered responses and a response timeout.

---
 rtl/ysyx_23060061_mem_pkg.sv | 20 ++
 rtl/ysyx_23060061_rr_arb2.sv | 35 +++
 rtl/ysyx_23060061_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_23060061_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060061_mem_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_23060061_mem_pkg;

  // Default bus widths of the core's memory port.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Owner of the outstanding transaction; also the grant-vector bit index.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/ysyx_23060061_rr_arb2.sv
// Two-way round-robin grant. The pointer remembers who was granted last and
// only moves when the grant is actually accepted.
module ysyx_23060061_rr_arb2
  import ysyx_23060061_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_r;

  // One-hot grant; on a tie the requester not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_r == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Last-grant pointer; reset value makes the IFU win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= OWN_LSU;
    end else if (accept) begin
      last_r <= grant[1] ? OWN_LSU : OWN_IFU;
    end
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Shares the core's single handshake memory port between IFU and LSU.
// One outstanding transaction, round-robin grant, registered responses and
// a WAIT-state timeout that returns an error response.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_mem_pkg::*;
#(
  parameter int          ADDR_W  = DEF_ADDR_W,
  parameter int          DATA_W  = DEF_DATA_W,
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t                state_r, state_s;
  logic                  owner_r;
  logic                  mem_req_valid_r;
  logic [ADDR_W-1:0]     mem_addr_r;
  logic                  mem_wen_r;
  logic [DATA_W-1:0]     mem_wdata_r;
  logic [DATA_W/8-1:0]   mem_wmask_r;
  logic [15:0]           cnt_r;
  logic                  ifu_resp_valid_r, lsu_resp_valid_r;
  logic                  ifu_resp_err_r, lsu_resp_err_r;
  logic [DATA_W-1:0]     ifu_rdata_r, lsu_rdata_r;

  logic                  accept_window_s;
  logic [1:0]            req_s;
  logic [1:0]            grant_s;
  logic                  accept_s;
  logic                  timeout_s;
  logic                  done_s;
  logic [DATA_W-1:0]     resp_data_s;

  // Grants are only offered in IDLE/RESP; gating with rst keeps ready low in reset.
  assign accept_window_s = rst && ((state_r == ST_IDLE) || (state_r == ST_RESP));
  assign req_s           = accept_window_s ? {lsu_req_valid, ifu_req_valid} : 2'b00;
  assign accept_s        = |grant_s;
  assign ifu_req_ready   = grant_s[OWN_IFU];
  assign lsu_req_ready   = grant_s[OWN_LSU];

  // A real response in the timeout cycle takes priority over the error.
  assign timeout_s   = (TIMEOUT != 16'd0) && (cnt_r == (TIMEOUT - 16'd1));
  assign done_s      = (state_r == ST_WAIT) && (mem_resp_valid || timeout_s);
  assign resp_data_s = mem_resp_valid ? mem_rdata : {DATA_W{1'b0}};

  ysyx_23060061_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .accept (accept_s),
    .grant  (grant_s)
  );

  // Next-state logic for the single-outstanding transaction FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_REQ;
        else          state_s = ST_IDLE;
      end
      ST_REQ: begin
        if (mem_req_ready) state_s = ST_WAIT;
        else               state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (done_s) state_s = ST_RESP;
        else        state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (accept_s) state_s = ST_REQ;
        else          state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_s;
  end

  // Owner and memory payload, captured only when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r     <= OWN_IFU;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wen_r   <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_wmask_r <= {(DATA_W/8){1'b0}};
    end else if (accept_s) begin
      if (grant_s[OWN_LSU]) begin
        owner_r     <= OWN_LSU;
        mem_addr_r  <= lsu_addr;
        mem_wen_r   <= lsu_wen;
        mem_wdata_r <= lsu_wdata;
        mem_wmask_r <= lsu_wmask;
      end else begin
        owner_r     <= OWN_IFU;
        mem_addr_r  <= ifu_addr;
        mem_wen_r   <= 1'b0;
        mem_wdata_r <= {DATA_W{1'b0}};
        mem_wmask_r <= {(DATA_W/8){1'b0}};
      end
    end
  end

  // Memory request valid is high exactly while the FSM sits in REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_req_valid_r <= 1'b0;
    else      mem_req_valid_r <= (state_s == ST_REQ);
  end

  // WAIT-cycle counter: cleared on the request handshake, counts in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 16'd0;
    end else if ((state_r == ST_REQ) && mem_req_ready) begin
      cnt_r <= 16'd0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // Registered one-cycle response routed to the owner only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifu_resp_valid_r <= 1'b0;
      ifu_rdata_r      <= {DATA_W{1'b0}};
      ifu_resp_err_r   <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      lsu_rdata_r      <= {DATA_W{1'b0}};
      lsu_resp_err_r   <= 1'b0;
    end else if (done_s) begin
      ifu_resp_valid_r <= (owner_r == OWN_IFU);
      ifu_rdata_r      <= (owner_r == OWN_IFU) ? resp_data_s : {DATA_W{1'b0}};
      ifu_resp_err_r   <= (owner_r == OWN_IFU) && !mem_resp_valid;
      lsu_resp_valid_r <= (owner_r == OWN_LSU);
      lsu_rdata_r      <= (owner_r == OWN_LSU) ? resp_data_s : {DATA_W{1'b0}};
      lsu_resp_err_r   <= (owner_r == OWN_LSU) && !mem_resp_valid;
    end else begin
      ifu_resp_valid_r <= 1'b0;
      ifu_rdata_r      <= {DATA_W{1'b0}};
      ifu_resp_err_r   <= 1'b0;
      lsu_resp_valid_r <= 1'b0;
      lsu_rdata_r      <= {DATA_W{1'b0}};
      lsu_resp_err_r   <= 1'b0;
    end
  end

  assign mem_req_valid  = mem_req_valid_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wen        = mem_wen_r;
  assign mem_wdata      = mem_wdata_r;
  assign mem_wmask      = mem_wmask_r;
  assign ifu_resp_valid = ifu_resp_valid_r;
  assign ifu_rdata      = ifu_rdata_r;
  assign ifu_resp_err   = ifu_resp_err_r;
  assign lsu_resp_valid = lsu_resp_valid_r;
  assign lsu_rdata      = lsu_rdata_r;
  assign lsu_resp_err   = lsu_resp_err_r;

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Directed plus randomized bench for the IFU/LSU memory arbiter. The bench
// plays both requesters and the memory; expectations come from a
// transaction-level model of the arbitration, payload and timeout rules.
module tb_ysyx_23060061_mem_arbiter;

  localparam int          TO   = 8;
  localparam logic [15:0] TO_P = 16'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  // model state: who was granted last, and the response due in the next checked cycle
  bit          last_lsu;
  bit          pend;
  bit          pend_lsu;
  logic [31:0] pend_rdata;
  bit          pend_err;

  always #5 clk = ~clk;

  ysyx_23060061_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO_P)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic check_resp();
    chk1 ("ifu_resp_valid", ifu_resp_valid, pend && !pend_lsu);
    chk32("ifu_rdata",      ifu_rdata,      (pend && !pend_lsu) ? pend_rdata : 32'h0);
    chk1 ("ifu_resp_err",   ifu_resp_err,   pend && !pend_lsu && pend_err);
    chk1 ("lsu_resp_valid", lsu_resp_valid, pend && pend_lsu);
    chk32("lsu_rdata",      lsu_rdata,      (pend && pend_lsu) ? pend_rdata : 32'h0);
    chk1 ("lsu_resp_err",   lsu_resp_err,   pend && pend_lsu && pend_err);
    pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1 ({tag, "_ifu_ready"}, ifu_req_ready, 1'b0);
    chk1 ({tag, "_lsu_ready"}, lsu_req_ready, 1'b0);
    chk1 ({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk1 ({tag, "_mem_wen"}, mem_wen, 1'b0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, "_mem_wmask"}, {28'h0, mem_wmask}, 32'h0);
    chk1 ({tag, "_ifu_resp_valid"}, ifu_resp_valid, 1'b0);
    chk32({tag, "_ifu_rdata"}, ifu_rdata, 32'h0);
    chk1 ({tag, "_ifu_resp_err"}, ifu_resp_err, 1'b0);
    chk1 ({tag, "_lsu_resp_valid"}, lsu_resp_valid, 1'b0);
    chk32({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
    chk1 ({tag, "_lsu_resp_err"}, lsu_resp_err, 1'b0);
  endtask

  // One cycle with no requests; memory noise must be ignored.
  task automatic idle_cyc();
    ifu_req_valid  = 1'b0;
    lsu_req_valid  = 1'b0;
    mem_req_ready  = rbit();
    mem_resp_valid = rbit();
    mem_rdata      = $urandom;
    settle();
    check_resp();
    chk1("idle_ifu_ready", ifu_req_ready, 1'b0);
    chk1("idle_lsu_ready", lsu_req_ready, 1'b0);
    chk1("idle_mem_req_valid", mem_req_valid, 1'b0);
    tick();
  endtask

  // One full transaction: accept cycle, rdly stalled REQ cycles, then memory
  // answers in WAIT cycle wdly (or never, if wdly >= TO). Returns in the RESP cycle.
  task automatic txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                     input bit wen, input logic [31:0] wd, input logic [3:0] wm,
                     input int rdly, input int wdly, input logic [31:0] rd);
    bit          win_lsu;
    logic [31:0] e_addr;
    bit          e_wen;
    logic [3:0]  e_wm;
    bit          to;
    int          waits;
    win_lsu = (iv && lv) ? !last_lsu : lv;
    e_addr  = win_lsu ? la : ia;
    e_wen   = win_lsu ? wen : 1'b0;
    e_wm    = win_lsu ? wm : 4'h0;
    // accept cycle (may coincide with the previous transaction's RESP)
    ifu_req_valid = iv;  ifu_addr  = ia;
    lsu_req_valid = lv;  lsu_addr  = la;
    lsu_wen       = wen; lsu_wdata = wd; lsu_wmask = wm;
    mem_req_ready = 1'b0; mem_resp_valid = rbit(); mem_rdata = $urandom;
    settle();
    check_resp();
    chk1("ifu_req_ready", ifu_req_ready, !win_lsu);
    chk1("lsu_req_ready", lsu_req_ready, win_lsu);
    last_lsu = win_lsu;
    tick();
    // request phase: payload must hold while requester inputs wander
    for (int k = 0; k <= rdly; k++) begin
      ifu_req_valid = rbit(); lsu_req_valid = rbit();
      ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
      lsu_wmask = 4'($urandom); lsu_wen = rbit();
      mem_req_ready = (k == rdly); mem_resp_valid = rbit(); mem_rdata = $urandom;
      settle();
      chk1 ("req_mem_req_valid", mem_req_valid, 1'b1);
      chk32("req_mem_addr", mem_addr, e_addr);
      chk1 ("req_mem_wen", mem_wen, e_wen);
      chk32("req_mem_wmask", {28'h0, mem_wmask}, {28'h0, e_wm});
      if (win_lsu) chk32("req_mem_wdata", mem_wdata, wd);
      else         chk1("req_no_ifu_wdata_check", 1'b0, 1'b0);
      chk1("req_ifu_ready", ifu_req_ready, 1'b0);
      chk1("req_lsu_ready", lsu_req_ready, 1'b0);
      chk1("req_ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("req_lsu_resp_valid", lsu_resp_valid, 1'b0);
      tick();
    end
    // wait phase: response at WAIT cycle wdly, or error after TO cycles
    to    = (wdly > TO - 1);
    waits = to ? TO : wdly + 1;
    for (int k = 0; k < waits; k++) begin
      ifu_req_valid = rbit(); lsu_req_valid = rbit();
      mem_req_ready = rbit();
      mem_resp_valid = (k == wdly);
      mem_rdata      = (k == wdly) ? rd : $urandom;
      settle();
      chk1("wait_mem_req_valid", mem_req_valid, 1'b0);
      chk1("wait_ifu_ready", ifu_req_ready, 1'b0);
      chk1("wait_lsu_ready", lsu_req_ready, 1'b0);
      chk1("wait_ifu_resp_valid", ifu_resp_valid, 1'b0);
      chk1("wait_lsu_resp_valid", lsu_resp_valid, 1'b0);
      tick();
    end
    mem_resp_valid = 1'b0;
    pend       = 1'b1;
    pend_lsu   = win_lsu;
    pend_rdata = to ? 32'h0 : rd;
    pend_err   = to;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit iv, lv;
    // reset state, with requests already asserted
    rst = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 32'h0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    last_lsu = 1'b1; pend = 1'b0; pend_lsu = 1'b0; pend_rdata = 32'h0; pend_err = 1'b0;
    #3;
    check_all_zero("reset");
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst = 1'b1;
    idle_cyc();

    // three back-to-back ties after reset: IFU, LSU, IFU, accepted in RESP
    txn(1'b1, 1'b1, 32'h8000_0100, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 0, 0, 32'h1111_1111);
    txn(1'b1, 1'b1, 32'h8000_0104, 32'h8000_0204, 1'b1, 32'hCAFE_0001, 4'hF, 0, 0, 32'h2222_2222);
    txn(1'b1, 1'b1, 32'h8000_0108, 32'h8000_0208, 1'b0, 32'h0, 4'h0, 0, 0, 32'h3333_3333);
    idle_cyc();

    // IFU-only minimum-latency read
    txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0010_0073);
    idle_cyc();

    // LSU store with memory stalling the request for 4 cycles
    txn(1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 4, 0, 32'h5A5A_5A5A);
    idle_cyc();

    // timeout with no response, then response exactly at the timeout cycle
    txn(1'b0, 1'b1, 32'h0, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 0, 50, 32'hFFFF_FFFF);
    txn(1'b0, 1'b1, 32'h0, 32'h8000_3004, 1'b0, 32'h0, 4'h0, 0, TO - 1, 32'h7777_0007);
    txn(1'b0, 1'b1, 32'h0, 32'h8000_3008, 1'b0, 32'h0, 4'h0, 1, TO - 2, 32'h6666_0006);
    idle_cyc();

    // reset in the middle of WAIT after an IFU grant
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b0; ifu_addr = 32'h8000_2000;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    settle();
    chk1("rstw_accept", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    chk1("rstw_req", mem_req_valid, 1'b1);
    tick();
    mem_req_ready = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_wait");
    tick();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    rst = 1'b1;
    last_lsu = 1'b1; pend = 1'b0;
    for (int i = 0; i < 3; i++) idle_cyc();
    txn(1'b1, 1'b1, 32'h8000_4000, 32'h8000_5000, 1'b0, 32'h0, 4'h0, 0, 1, 32'h4444_4444);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      iv = rbit();
      lv = rbit();
      if (!iv && !lv) iv = 1'b1;
      txn(iv, lv, $urandom, $urandom, rbit(), $urandom, 4'($urandom),
          int'($urandom_range(3, 0)), int'($urandom_range(11, 0)), $urandom);
      if (rbit()) idle_cyc();
    end
    idle_cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
